// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Pong game-flow controller: FSM state encoding
// (also exported on the state output for the text overlay) and default
// parameter values.
// -----------------------------------------------------------------------------
package pong_pkg;

  localparam int STATE_W         = 2;
  localparam int TIMER_TICKS_DEF = 120;  // 2 s of frame ticks at 60 Hz
  localparam int LIVES_DEF       = 3;

  typedef enum logic [STATE_W-1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl_if
// Signal bundle between the graphics engine / score counter side (master) and
// the game-flow controller (slave).
//   master drives : btn[1:0], hit, miss, refr_tick
//   slave drives  : d_inc, d_clr, graph_still, game_over, lives, state
// -----------------------------------------------------------------------------
interface pong_game_ctrl_if #(
  parameter int LIFE_W = 2
);

  logic [1:0]                  btn;
  logic                        hit;
  logic                        miss;
  logic                        refr_tick;
  logic                        d_inc;
  logic                        d_clr;
  logic                        graph_still;
  logic                        game_over;
  logic [LIFE_W-1:0]           lives;
  logic [pong_pkg::STATE_W-1:0] state;

  modport master (
    output btn, hit, miss, refr_tick,
    input  d_inc, d_clr, graph_still, game_over, lives, state
  );

  modport slave (
    input  btn, hit, miss, refr_tick,
    output d_inc, d_clr, graph_still, game_over, lives, state
  );

endinterface

// File: rtl/pong_timer.sv
// -----------------------------------------------------------------------------
// pong_timer
// 8-bit frame-tick down-counter used for the inter-round and game-over delay.
//   clk, reset : clock and asynchronous active-high reset
//   start      : load TICKS-1 (reloads if already running)
//   tick       : decrement by one while nonzero, saturating at zero
//   done       : count is zero and no start is being applied this cycle
// -----------------------------------------------------------------------------
module pong_timer
  import pong_pkg::*;
#(
  parameter int TICKS = TIMER_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic done
);

  localparam logic [7:0] LOAD_VAL = 8'(TICKS - 1);

  logic [7:0] r_count;

  // Down-counter: start has priority over tick so a restart always reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (start) begin
      r_count <= LOAD_VAL;
    end else if (tick && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  // A start in flight masks an expired count so the FSM never sees a stale done.
  assign done = (r_count == 8'd0) && !start;

endmodule

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
// Game-flow controller for Pong. Converts hit/miss events into one-cycle score
// commands (d_inc on a hit, d_clr on a new game), tracks remaining balls and
// sequences NEWGAME -> PLAY -> NEWBALL/OVER with a frame-tick delay.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : pong_game_ctrl_if.slave (btn, hit, miss, refr_tick in;
//                d_inc, d_clr, graph_still, game_over, lives, state out)
// -----------------------------------------------------------------------------
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES       = LIVES_DEF,
  parameter int LIFE_W      = 2,
  parameter int TIMER_TICKS = TIMER_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  pong_game_ctrl_if.slave      bus
);

  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] ONE_LIFE   = LIFE_W'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [LIFE_W-1:0] r_lives;
  logic [LIFE_W-1:0] w_lives_next;
  logic              r_d_inc;
  logic              r_d_clr;
  logic              w_d_inc_next;
  logic              w_d_clr_next;
  logic              w_timer_start;
  logic              w_timer_done;

  pong_timer #(
    .TICKS (TIMER_TICKS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (w_timer_start),
    .tick  (bus.refr_tick),
    .done  (w_timer_done)
  );

  // State, lives and score-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= NEWGAME;
      r_lives <= LIVES_INIT;
      r_d_inc <= 1'b0;
      r_d_clr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lives <= w_lives_next;
      r_d_inc <= w_d_inc_next;
      r_d_clr <= w_d_clr_next;
    end
  end

  // Next-state, lives update, score commands and timer start.
  always_comb begin
    w_state_next  = r_state;
    w_lives_next  = r_lives;
    w_d_inc_next  = 1'b0;
    w_d_clr_next  = 1'b0;
    w_timer_start = 1'b0;
    case (r_state)
      NEWGAME: begin
        if (bus.btn != 2'b00) begin
          w_state_next = PLAY;
          w_d_clr_next = 1'b1;
        end else begin
          w_state_next = NEWGAME;
        end
      end
      PLAY: begin
        // miss outranks hit: a ball lost in the same cycle scores nothing
        if (bus.miss) begin
          w_timer_start = 1'b1;
          if (r_lives > ONE_LIFE) begin
            w_lives_next = r_lives - ONE_LIFE;
            w_state_next = NEWBALL;
          end else begin
            w_lives_next = '0;
            w_state_next = OVER;
          end
        end else if (bus.hit) begin
          w_d_inc_next = 1'b1;
        end else begin
          w_state_next = PLAY;
        end
      end
      NEWBALL: begin
        if (w_timer_done && (bus.btn != 2'b00)) begin
          w_state_next = PLAY;
        end else begin
          w_state_next = NEWBALL;
        end
      end
      OVER: begin
        if (w_timer_done) begin
          w_state_next = NEWGAME;
          w_lives_next = LIVES_INIT;
        end else begin
          w_state_next = OVER;
        end
      end
      default: begin
        w_state_next = NEWGAME;
        w_lives_next = LIVES_INIT;
      end
    endcase
  end

  // Flags are decoded straight from the state register so they move with it.
  assign bus.graph_still = (r_state != PLAY);
  assign bus.game_over   = (r_state == OVER);
  assign bus.state       = r_state;
  assign bus.lives       = r_lives;
  assign bus.d_inc       = r_d_inc;
  assign bus.d_clr       = r_d_clr;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
// Self-checking bench for pong_game_ctrl with TIMER_TICKS=4, LIVES=3.
// A game-rule model predicts every output each cycle; directed scenarios add
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

  localparam int LIVES = 3;
  localparam int TICKS = 4;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;
  int inc_cnt  = 0;
  int clr_cnt  = 0;

  // Model of the game rules (0=NEWGAME,1=PLAY,2=NEWBALL,3=OVER)
  int m_state;
  int m_lives;
  int m_timer;
  bit m_inc;
  bit m_clr;
  bit m_init = 1'b0;

  pong_game_ctrl_if #(.LIFE_W(2)) bus ();

  pong_game_ctrl #(
    .LIVES       (LIVES),
    .LIFE_W      (2),
    .TIMER_TICKS (TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; returns just after the active edge.
  task automatic step(input logic [1:0] b, input logic h, input logic m, input logic t);
    @(negedge clk);
    bus.btn       = b;
    bus.hit       = h;
    bus.miss      = m;
    bus.refr_tick = t;
    @(posedge clk);
    #1;
  endtask

  // Game-rule model, advanced on every clock edge.
  always @(posedge clk or posedge reset) begin : model
    int ns, nl, nt;
    bit st, pi, pc;
    if (reset) begin
      m_state <= 0;
      m_lives <= LIVES;
      m_timer <= 0;
      m_inc   <= 1'b0;
      m_clr   <= 1'b0;
      m_init  <= 1'b1;
    end else begin
      ns = m_state; nl = m_lives; nt = m_timer;
      st = 1'b0; pi = 1'b0; pc = 1'b0;
      if (m_state == 0) begin
        if (bus.btn != 2'b00) begin ns = 1; pc = 1'b1; end
      end else if (m_state == 1) begin
        if (bus.miss) begin
          st = 1'b1;
          nl = m_lives - 1;
          ns = (nl > 0) ? 2 : 3;
        end else if (bus.hit) begin
          pi = 1'b1;
        end
      end else if (m_state == 2) begin
        if (m_timer == 0 && bus.btn != 2'b00) ns = 1;
      end else begin
        if (m_timer == 0) begin ns = 0; nl = LIVES; end
      end
      if (st) nt = TICKS - 1;
      else if (bus.refr_tick && m_timer > 0) nt = m_timer - 1;
      m_state <= ns;
      m_lives <= nl;
      m_timer <= nt;
      m_inc   <= pi;
      m_clr   <= pc;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_state",       int'(bus.state),       m_state);
      chk("cmp_lives",       int'(bus.lives),       m_lives);
      chk("cmp_d_inc",       int'(bus.d_inc),       int'(m_inc));
      chk("cmp_d_clr",       int'(bus.d_clr),       int'(m_clr));
      chk("cmp_graph_still", int'(bus.graph_still), (m_state != 1) ? 1 : 0);
      chk("cmp_game_over",   int'(bus.game_over),   (m_state == 3) ? 1 : 0);
    end
    if (bus.d_inc) inc_cnt++;
    if (bus.d_clr) clr_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr0;
    reset         = 1'b1;
    bus.btn       = 2'b00;
    bus.hit       = 1'b0;
    bus.miss      = 1'b0;
    bus.refr_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    repeat (10) step(2'b00, 1'b0, 1'b0, 1'b0);
    chk("t1_state", int'(bus.state), 0);
    chk("t1_graph_still", int'(bus.graph_still), 1);
    chk("t1_game_over", int'(bus.game_over), 0);
    chk("t1_lives", int'(bus.lives), 3);
    chk("t1_no_clr", clr_cnt, 0);
    chk("t1_no_inc", inc_cnt, 0);

    // 6a: hit/miss ignored in NEWGAME
    step(2'b00, 1'b1, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    chk("t6_newgame_inc", inc_cnt, 0);
    chk("t6_newgame_lives", int'(bus.lives), 3);
    chk("t6_newgame_state", int'(bus.state), 0);

    // 2: start game, then five hits
    step(2'b01, 1'b0, 1'b0, 1'b0);
    chk("t2_d_clr", int'(bus.d_clr), 1);
    chk("t2_state", int'(bus.state), 1);
    chk("t2_graph_still", int'(bus.graph_still), 0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    chk("t2_d_clr_width", int'(bus.d_clr), 0);
    chk("t2_clr_count", clr_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 1'b1, 1'b0, 1'b0);
      chk("t2_d_inc_hi", int'(bus.d_inc), 1);
      step(2'b00, 1'b0, 1'b0, 1'b0);
      chk("t2_d_inc_lo", int'(bus.d_inc), 0);
    end
    chk("t2_inc_count", inc_cnt, 5);

    // 3: hit+miss together, then wait out the timer with btn held
    step(2'b00, 1'b1, 1'b1, 1'b0);
    chk("t3_d_inc", int'(bus.d_inc), 0);
    chk("t3_lives", int'(bus.lives), 2);
    chk("t3_state", int'(bus.state), 2);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0, 1'b0, 1'b1);
      chk("t3_hold", int'(bus.state), 2);
    end
    step(2'b01, 1'b0, 1'b0, 1'b0);
    chk("t3_resume", int'(bus.state), 1);
    chk("t3_inc_count", inc_cnt, 5);

    // 4: down to the last ball, then game over
    step(2'b00, 1'b0, 1'b1, 1'b0);
    chk("t4_lives2to1", int'(bus.lives), 1);
    repeat (3) step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b0, 1'b0);
    chk("t4_play_again", int'(bus.state), 1);
    step(2'b00, 1'b0, 1'b1, 1'b0);
    chk("t4_lives0", int'(bus.lives), 0);
    chk("t4_over", int'(bus.state), 3);
    chk("t4_game_over", int'(bus.game_over), 1);
    // 6b: btn ignored in OVER while the timer runs
    step(2'b11, 1'b0, 1'b0, 1'b0);
    chk("t6_over_btn", int'(bus.state), 3);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b0, 1'b1);
    chk("t6_over_btn2", int'(bus.state), 3);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    chk("t4_over_last", int'(bus.state), 3);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    chk("t4_newgame", int'(bus.state), 0);
    chk("t4_lives_reload", int'(bus.lives), 3);
    chk("t4_game_over_off", int'(bus.game_over), 0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    chk("t4_no_clr", int'(bus.d_clr), 0);

    // 5: asynchronous reset in NEWBALL with the timer at 2
    step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1, 1'b0);
    chk("t5_newball", int'(bus.state), 2);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_state", int'(bus.state), 0);
    chk("t5_rst_lives", int'(bus.lives), 3);
    chk("t5_rst_graph_still", int'(bus.graph_still), 1);
    chk("t5_rst_d_clr", int'(bus.d_clr), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clr0 = clr_cnt;
    repeat (3) step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    chk("t5_one_clr", clr_cnt - clr0, 1);
    chk("t5_state", int'(bus.state), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
